vga_playfield_renderer: RTL and testbench
=========================================

# vga_playfield_renderer

Parametrised successor renderer for the frog game's VGA output. It generates 640x480 timing from a free-running pixel clock and draws an N-car playfield over an external background and an external frog sprite. Cars have per-car lengths and wrap horizontally across the grid. Object positions are shadowed once per frame, and frog/car pixel overlap is reported as a per-frame collision flag to the game FSM.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33
- CELL_LOG2, 5, log2 of cell size in pixels (32x32 cells); GRID_COLS = H_ACTIVE>>CELL_LOG2 (20), GRID_ROWS = V_ACTIVE>>CELL_LOG2 (15)
- N_CARS, 11, number of car slots
- FROG_RGB, 9'h1FF, frog colour {r,g,b} 3 bits each; CAR_RGB, 9'h1C0, car colour
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous, active-low reset
- frog_col  in  5  frog grid column
- frog_row  in  4  frog grid row
- car_x  in  5*N_CARS  packed car columns, car i at [5i+4:5i]
- car_y  in  4*N_CARS  packed car rows, car i at [4i+3:4i]
- car_len  in  3*N_CARS  packed car lengths in cells; 0 = slot empty
- px_x  out  10  current pixel column (stage 0), to background/sprite logic
- px_y  out  9  current pixel row (stage 0)
- px_active  out  1  stage-0 pixel is visible
- bg_rgb  in  9  background colour for px_x/px_y, combinational from stage 0
- sprite_px  in  1  frog sprite bit for (px_x, px_y) mod cell, combinational from stage 0
- vga_r, vga_g, vga_b  out  3 each  colour
- vga_hs, vga_vs  out  1 each  sync, active-low
- frame_tick  out  1  one-cycle pulse at start of vertical blank
- collision  out  1  frog/car overlap occurred in last completed frame

## Operation
- Counters: h_cnt 0..H_total-1 (800), v_cnt 0..V_total-1 (525). v_cnt advances when h_cnt wraps. Line order: active, front porch, sync, back porch. Visible region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. px_x=h_cnt and px_y=v_cnt.
- Stage 1 registers: col=px_x>>CELL_LOG2, row=px_y>>CELL_LOG2, bg_rgb, sprite_px, syncs, active, frog_hit, car_hit.
- frog_hit: active && col==frog_col_s && row==frog_row_s && sprite_px.
- car_hit: OR over i of (row==car_y_s[i] && car_len_s[i]!=0 && car_x_s[i]<GRID_COLS && d<car_len_s[i]).
  - d=(col-car_x_s[i]) mod GRID_COLS, computed in 6 bits; if the raw difference is negative, add GRID_COLS.
  - A car with x=18 and len=4 covers columns 18, 19, 0, 1.
- Stage 2 (outputs): if not active, RGB=0. Otherwise frog_hit gives FROG_RGB, else car_hit gives CAR_RGB, else bg_rgb.
- Shadowing: *_s registers load from the input ports on the cycle frame_tick is asserted, i.e. when (h_cnt,v_cnt) enters (0,V_ACTIVE). Input changes at any other time do not affect the frame being drawn.
- frame_tick is registered and asserted one cycle after that counter state.
- Collision: coll_acc sets on any stage-1 cycle with frog_hit && car_hit. On the frame_tick cycle, collision<=coll_acc, or <=1 if a hit occurs on that same cycle; coll_acc then clears. collision holds until the next frame_tick.
- Reset (async assert, sync release):
  - counters, all shadow registers, coll_acc: 0; car_len_s=0, so nothing is drawn until the first frame_tick
  - vga_r/g/b=0, vga_hs=vga_vs=1, frame_tick=0, collision=0, px_active=0
  - Reset mid-frame restarts at (0,0) with no partial pulses.

## Timing
- Colour and sync are both delayed 2 cycles from the counters, so they remain mutually aligned. vga_hs is low for exactly 96 clocks per line, and vga_vs is low for exactly 2 lines.
- bg_rgb and sprite_px must settle within the stage-0 cycle (combinational path from px_x/px_y).
- Line period is 800 clocks; frame period is 420,000 clocks; frame_tick period is 420,000 clocks.
- The first frame_tick after reset occurs 480*800+1 clocks after reset release.

## Configuration
- VGA_COLLISION_EN defined: coll_acc and the collision output are implemented as described.
- Undefined: collision is tied to 0 and coll_acc is not built. Rendering and frame_tick are unchanged.

## Test plan
- Reset, then run 2 frames: hs low 96 clocks per 800, vs low 1600 clocks per 420,000. Colour is 0 outside active; frame_tick fires once per frame.
- Wrap case: bg_rgb=0, car0 x=18 y=3 len=4, other len=0, shadowed. Row 3 columns 18, 19, 0, 1 are 3'b111/000/000; column 2 and column 17 are bg.
- frog_col=5, frog_row=7, sprite_px=1, car0 x=4 y=7 len=3: cell (5,7) shows FROG_RGB, collision=1 after the next frame_tick. Same setup with sprite_px=0: cell shows CAR_RGB and collision=0.
- Change car_x mid-frame at v_cnt=100: the current frame is unchanged, and the new position appears only in the frame after frame_tick.
- Assert rst_n low at v_cnt=200: outputs go to reset values immediately, and counters restart at (0,0) on release.
- Build without VGA_COLLISION_EN and repeat the overlap case: collision stays 0 and the pixels are identical.

Source files
------------

// File: rtl/vga_playfield_renderer.sv
// vga_playfield_renderer: 640x480 VGA timing with a shadowed N-car playfield,
// external background and frog sprite, and a per-frame frog/car collision flag.
// Optional feature macro: VGA_COLLISION_EN (builds coll_acc and the collision output).
// Pipeline: stage 0 = counters + combinational hit tests, stage 1 = hit/sync
// registers, stage 2 = colour/sync output registers.

// Per-car cell test: row match, non-empty slot, on-grid column, and the
// column lying within len cells to the right of x with horizontal wrap.
module vga_car_lane #(
   parameter logic [5:0] GRID_COLS = 6'd20
) (
   input  logic [5:0] i_col,
   input  logic [4:0] i_row,
   input  logic [4:0] i_x,
   input  logic [3:0] i_y,
   input  logic [2:0] i_len,
   output logic       o_hit
);
   logic [5:0] w_diff;
   logic [5:0] w_d;

   // Column and x are both below 32, so bit 5 of the difference is its sign.
   assign w_diff = i_col - {1'b0, i_x};
   assign w_d    = w_diff[5] ? (w_diff + GRID_COLS) : w_diff;
   assign o_hit  = (i_row == {1'b0, i_y}) && (i_len != 3'd0) &&
                   ({1'b0, i_x} < GRID_COLS) && (w_d < {3'b000, i_len});
endmodule

module vga_playfield_renderer #(
   parameter int         H_ACTIVE  = 640,
   parameter int         H_FP      = 16,
   parameter int         H_SYNC    = 96,
   parameter int         H_BP      = 48,
   parameter int         V_ACTIVE  = 480,
   parameter int         V_FP      = 10,
   parameter int         V_SYNC    = 2,
   parameter int         V_BP      = 33,
   parameter int         CELL_LOG2 = 5,
   parameter int         N_CARS    = 11,
   parameter logic [8:0] FROG_RGB  = 9'h1FF,
   parameter logic [8:0] CAR_RGB   = 9'h1C0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [4:0]            i_frog_col,
   input  logic [3:0]            i_frog_row,
   input  logic [5*N_CARS-1:0]   i_car_x,
   input  logic [4*N_CARS-1:0]   i_car_y,
   input  logic [3*N_CARS-1:0]   i_car_len,
   output logic [9:0]            o_px_x,
   output logic [8:0]            o_px_y,
   output logic                  o_px_active,
   input  logic [8:0]            i_bg_rgb,
   input  logic                  i_sprite_px,
   output logic [2:0]            o_vga_r,
   output logic [2:0]            o_vga_g,
   output logic [2:0]            o_vga_b,
   output logic                  o_vga_hs,
   output logic                  o_vga_vs,
   output logic                  o_frame_tick,
   output logic                  o_collision
);
   localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [5:0] GRID_COLS = 6'(H_ACTIVE >> CELL_LOG2);

   logic [9:0] r_h_cnt, r_v_cnt;
   logic [4:0] r_frog_col_s;
   logic [3:0] r_frog_row_s;
   logic [N_CARS-1:0][4:0] r_car_x_s;
   logic [N_CARS-1:0][3:0] r_car_y_s;
   logic [N_CARS-1:0][2:0] r_car_len_s;
   logic       r_frame_tick;
   logic       r1_active, r1_hs, r1_vs, r1_frog_hit, r1_car_hit;
   logic [8:0] r1_bg;
   logic       r2_hs, r2_vs;
   logic [8:0] r2_rgb;

   logic       w_active, w_hs, w_vs, w_frog_hit;
   logic [5:0] w_col;
   logic [4:0] w_row;
   logic [N_CARS-1:0] w_car_hits;

   // Stage 0: pixel position and the combinational tests on it.
   assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign w_hs        = !((r_h_cnt >= H_SYNC_LO) && (r_h_cnt < H_SYNC_HI));
   assign w_vs        = !((r_v_cnt >= V_SYNC_LO) && (r_v_cnt < V_SYNC_HI));
   assign w_col       = 6'(r_h_cnt >> CELL_LOG2);
   assign w_row       = 5'(r_v_cnt >> CELL_LOG2);
   assign w_frog_hit  = w_active && (w_col == {1'b0, r_frog_col_s}) &&
                        (w_row == {1'b0, r_frog_row_s}) && i_sprite_px;
   assign o_px_x      = r_h_cnt;
   // px_y only needs the visible range; blanking rows past 511 alias harmlessly.
   assign o_px_y      = r_v_cnt[8:0];
   // Counters sit at (0,0) during reset, so visibility is masked by reset itself.
   assign o_px_active = w_active && i_rst_n;

   for (genvar g = 0; g < N_CARS; g++) begin : g_lane
      vga_car_lane #(.GRID_COLS(GRID_COLS)) u_lane (
         .i_col (w_col),
         .i_row (w_row),
         .i_x   (r_car_x_s[g]),
         .i_y   (r_car_y_s[g]),
         .i_len (r_car_len_s[g]),
         .o_hit (w_car_hits[g])
      );
   end

   // Free-running raster counters; v advances on each h wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 10'd1;
      end
   end

   // Frame tick one cycle after entering (0,V_ACTIVE); shadows load on that tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_frame_tick <= 1'b0;
         r_frog_col_s <= '0;
         r_frog_row_s <= '0;
         r_car_x_s    <= '0;
         r_car_y_s    <= '0;
         r_car_len_s  <= '0;
      end else begin
         r_frame_tick <= (r_h_cnt == 10'd0) && (r_v_cnt == V_ACT);
         if (r_frame_tick) begin
            r_frog_col_s <= i_frog_col;
            r_frog_row_s <= i_frog_row;
            r_car_x_s    <= i_car_x;
            r_car_y_s    <= i_car_y;
            r_car_len_s  <= i_car_len;
         end
      end
   end

   // Stages 1 and 2: register hits/syncs, then resolve priority into colour.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r1_active   <= 1'b0;
         r1_hs       <= 1'b1;
         r1_vs       <= 1'b1;
         r1_bg       <= '0;
         r1_frog_hit <= 1'b0;
         r1_car_hit  <= 1'b0;
         r2_hs       <= 1'b1;
         r2_vs       <= 1'b1;
         r2_rgb      <= '0;
      end else begin
         r1_active   <= w_active;
         r1_hs       <= w_hs;
         r1_vs       <= w_vs;
         r1_bg       <= i_bg_rgb;
         r1_frog_hit <= w_frog_hit;
         r1_car_hit  <= |w_car_hits;
         r2_hs       <= r1_hs;
         r2_vs       <= r1_vs;
         if (!r1_active)       r2_rgb <= '0;
         else if (r1_frog_hit) r2_rgb <= FROG_RGB;
         else if (r1_car_hit)  r2_rgb <= CAR_RGB;
         else                  r2_rgb <= r1_bg;
      end
   end

   assign o_vga_r      = r2_rgb[8:6];
   assign o_vga_g      = r2_rgb[5:3];
   assign o_vga_b      = r2_rgb[2:0];
   assign o_vga_hs     = r2_hs;
   assign o_vga_vs     = r2_vs;
   assign o_frame_tick = r_frame_tick;

`ifdef VGA_COLLISION_EN
   logic r_coll_acc, r_collision;
   logic w_hit;

   assign w_hit = r1_frog_hit && r1_car_hit;

   // Accumulate overlap over the frame; publish and clear on the frame tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_coll_acc  <= 1'b0;
         r_collision <= 1'b0;
      end else if (r_frame_tick) begin
         r_collision <= r_coll_acc || w_hit;
         r_coll_acc  <= 1'b0;
      end else if (w_hit) begin
         r_coll_acc  <= 1'b1;
      end
   end

   assign o_collision = r_collision;
`else
   assign o_collision = 1'b0;
`endif
endmodule

// File: tb/tb_vga_playfield_renderer.sv
// Scoreboard bench for vga_playfield_renderer on a scaled-down raster
// (100x67 total, 80x60 visible, 4-pixel cells -> same 20x15 grid).
`timescale 1ns/1ps
module tb_vga_playfield_renderer;
   localparam int HT = 100, VT = 67, FT = HT * VT, HA = 80, VA = 60;
   localparam int NC = 11;
   localparam logic [8:0] FROG = 9'h1FF, CAR = 9'h1C0;
`ifdef VGA_COLLISION_EN
   localparam bit EXP_COLL = 1'b1;
`else
   localparam bit EXP_COLL = 1'b0;
`endif

   typedef struct {
      int         t;
      bit         coll;
      logic [8:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] frog_col;
   logic [3:0] frog_row;
   logic [5*NC-1:0] car_x;
   logic [4*NC-1:0] car_y;
   logic [3*NC-1:0] car_len;
   logic [9:0] px_x;
   logic [8:0] px_y;
   logic px_active;
   logic [8:0] bg_rgb;
   logic sprite_px, spr;
   logic [2:0] vga_r, vga_g, vga_b;
   logic vga_hs, vga_vs, frame_tick, collision;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;
   int   cnt = 0;
   bit   rel = 1'b0;

   vga_playfield_renderer #(
      .H_ACTIVE(HA), .H_FP(4), .H_SYNC(12), .H_BP(4),
      .V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .CELL_LOG2(2), .N_CARS(NC), .FROG_RGB(FROG), .CAR_RGB(CAR)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_frog_col(frog_col), .i_frog_row(frog_row),
      .i_car_x(car_x), .i_car_y(car_y), .i_car_len(car_len),
      .o_px_x(px_x), .o_px_y(px_y), .o_px_active(px_active),
      .i_bg_rgb(bg_rgb), .i_sprite_px(sprite_px),
      .o_vga_r(vga_r), .o_vga_g(vga_g), .o_vga_b(vga_b),
      .o_vga_hs(vga_hs), .o_vga_vs(vga_vs),
      .o_frame_tick(frame_tick), .o_collision(collision)
   );

   always #5 clk = ~clk;

   // Background/sprite source: position-dependent so pipeline skew shows up.
   always_comb begin
      bg_rgb    = {px_x[2:0], px_y[2:0], 3'b101};
      sprite_px = spr && (px_x[1:0] == 2'd1);
   end

   // Posedges since reset release = raster index of the stage-0 pixel.
   always @(posedge clk) cnt <= rel ? cnt + 1 : 0;

   function automatic logic [8:0] bg_of(input int h, input int v);
      return {3'(h), 3'(v), 3'b101};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cnt=%0d)", nm, act, exp, cnt);
      end
   endtask

   // kind: 0 = background, 1 = car, 2 = frog; sampled at row offset 1 of the cell.
   task automatic px(input int f, input int cx, input int cy, input int ox, input int kind);
      exp_t e;
      int h, v;
      h = cx * 4 + ox;
      v = cy * 4 + 1;
      e.t = f * FT + v * HT + h;
      e.coll = 1'b0;
      e.val = (kind == 2) ? FROG : (kind == 1) ? CAR : bg_of(h, v);
      q.push_back(e);
   endtask

   task automatic coll(input int f, input bit val);
      exp_t e;
      e.t = f * FT + HT;
      e.coll = 1'b1;
      e.val = {8'd0, val};
      q.push_back(e);
   endtask

   task automatic set_car(input int i, input int x, input int y, input int len);
      car_x[5*i +: 5]   = 5'(x);
      car_y[4*i +: 4]   = 4'(y);
      car_len[3*i +: 3] = 3'(len);
   endtask

   task automatic wait_cnt(input int n);
      while (cnt < n) @(negedge clk);
   endtask

   task automatic chk_reset_vals();
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 9'd0);
      chk("rst_hs", vga_hs, 1'b1);
      chk("rst_vs", vga_vs, 1'b1);
      chk("rst_tick", frame_tick, 1'b0);
      chk("rst_coll", collision, 1'b0);
      chk("rst_px_active", px_active, 1'b0);
      chk("rst_px_x", px_x, 10'd0);
      chk("rst_px_y", px_y, 9'd0);
   endtask

   // Monitor: raster/sync/tick model every cycle, scoreboard pops on matching pixel.
   always @(negedge clk) begin
      int k, p, h, v, hk, vk;
      if (rel && cnt >= 2) begin
         k = cnt; p = k - 2;
         h = p % HT; v = (p / HT) % VT;
         hk = k % HT; vk = (k / HT) % VT;
         chk("px_x", px_x, hk);
         chk("px_y", px_y, vk);
         chk("px_active", px_active, (hk < HA) && (vk < VA));
         chk("hsync", vga_hs, !(h >= HA + 4 && h < HA + 16));
         chk("vsync", vga_vs, !(v >= VA + 2 && v < VA + 4));
         chk("frame_tick", frame_tick, ((k - 1) % FT) == VA * HT);
         if (!(h < HA && v < VA)) chk("blank_rgb", {vga_r, vga_g, vga_b}, 9'd0);
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].t == p) begin
               if (q[i].coll) chk("collision", collision, q[i].val);
               else           chk($sformatf("rgb@%0d,%0d", h, v), {vga_r, vga_g, vga_b}, q[i].val);
               q.delete(i);
            end else if (q[i].t < p) begin
               n_chk++; n_fail++;
               $display("FAIL scoreboard: entry t=%0d not observed, now p=%0d", q[i].t, p);
               q.delete(i);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; spr = 1'b0;
      frog_col = 5'd10; frog_row = 4'd10;
      car_x = '0; car_y = '0; car_len = '0;
      set_car(0, 18, 3, 4);          // wraps: cols 18,19,0,1
      set_car(2, 25, 3, 2);          // off-grid x: never drawn
      repeat (3) @(negedge clk);
      #1 chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1; rel = 1'b1;

      // Frame 0 uses reset shadows: nothing drawn.
      px(0, 18, 3, 1, 0); px(0, 0, 3, 1, 0);
      // Frame 1: wrap case.
      px(1, 0, 3, 1, 1); px(1, 1, 3, 1, 1); px(1, 2, 3, 1, 0); px(1, 5, 3, 1, 0);
      px(1, 17, 3, 1, 0); px(1, 18, 3, 1, 1); px(1, 19, 3, 1, 1);
      px(1, 18, 2, 1, 0); px(1, 18, 4, 1, 0);
      coll(1, 1'b0);

      wait_cnt(FT + 100);
      frog_col = 5'd5; frog_row = 4'd7;
      set_car(0, 4, 7, 3);
      set_car(1, 15, 7, 2);
      px(2, 3, 7, 1, 0); px(2, 4, 7, 1, 1); px(2, 5, 7, 1, 2); px(2, 5, 7, 2, 1);
      px(2, 6, 7, 1, 1); px(2, 7, 7, 1, 0); px(2, 15, 7, 1, 1); px(2, 16, 7, 1, 1);
      px(2, 17, 7, 1, 0); px(2, 5, 3, 1, 0); px(2, 5, 6, 1, 0); px(2, 5, 8, 1, 0);
      coll(2, 1'b0);

      wait_cnt(FT + 6100);
      spr = 1'b1;

      wait_cnt(2 * FT + 6100);
      spr = 1'b0;
      px(3, 4, 7, 1, 1); px(3, 5, 7, 1, 1);
      coll(3, EXP_COLL);
      px(4, 4, 7, 1, 1); px(4, 10, 7, 1, 0);
      coll(4, 1'b0);

      // Mid-frame move at v=20: takes effect only after the next tick.
      wait_cnt(4 * FT + 20 * HT);
      set_car(0, 10, 7, 3);
      px(5, 4, 7, 1, 0); px(5, 5, 7, 1, 0); px(5, 10, 7, 1, 1);
      px(5, 12, 7, 1, 1); px(5, 13, 7, 1, 0);
      coll(5, 1'b0);
      px(6, 10, 7, 1, 1);

      // Reset in the middle of frame 6 (v=40).
      wait_cnt(6 * FT + 40 * HT + 50);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      q.delete();
      rst_n = 1'b0; rel = 1'b0;
      #1 chk_reset_vals();
      repeat (5) @(negedge clk);
      rst_n = 1'b1; rel = 1'b1;
      #1;
      chk("restart_px_x", px_x, 10'd0);
      chk("restart_px_y", px_y, 9'd0);
      chk("restart_active", px_active, 1'b1);
      px(0, 10, 7, 1, 0); px(0, 12, 7, 1, 0);
      coll(0, 1'b0);
      px(1, 10, 7, 1, 1); px(1, 11, 7, 1, 1); px(1, 4, 7, 1, 0);

      wait_cnt(FT + 4000);
      chk("queue_drained_end", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
